regfile_onehot_wr: RTL and testbench
====================================

# regfile_onehot_wr

Thirty-two-word by 32-bit register file that sits directly downstream of the 5-to-32 line decoder. It consumes the decoder's one-hot word-select as its write enable and provides two asynchronous read ports for the datapath. A one-entry pending-write stage buffers each accepted write until the pipeline's write-back control commits it. Reads bypass the pending stage, and malformed (non-one-hot) selects are trapped.

## Interface
- `WIDTH`, default 32: data word width.
- `DEPTH`, default 32: number of words. Fixed to 32 to match the decoder output; any other value is a configuration error.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `wr_valid`, in, 1: a write request is presented.
- `wr_ready`, out, 1: the block can accept a write this cycle.
- `wr_sel`, in, 32: one-hot word select from the line decoder; bit i selects word i.
- `wr_data`, in, WIDTH: write data.
- `commit_en`, in, 1: write-back enable; retires the pending write into the array.
- `rd_addr_a`, in, 5: read port A address.
- `rd_data_a`, out, WIDTH: read port A data.
- `rd_addr_b`, in, 5: read port B address.
- `rd_data_b`, out, WIDTH: read port B data.
- `sel_err`, out, 1: sticky flag; a non-one-hot `wr_sel` was accepted.
- `clr_err`, in, 1: synchronous clear of `sel_err`.

## Operation
- **Storage**
  - Array `mem[0..31]`, each WIDTH bits.
  - Word 0 is hardwired to zero: writes to it are accepted, counted as legal, and discarded.
- **Accept**
  - A write is accepted when `wr_valid && wr_ready`.
  - `wr_ready = !pend_vld || commit_en`.
- **Pending stage**
  - On accept, `pend_sel` ← `wr_sel` and `pend_data` ← `wr_data`.
  - `pend_vld` ← 1 if `wr_sel` is one-hot, otherwise 0.
- **Commit**
  - When `pend_vld && commit_en`, `mem[i]` ← `pend_data` for the single set bit i of `pend_sel`.
  - `pend_vld` then clears unless a new write is accepted in the same cycle.
- **Simultaneous commit and accept**
  - The old entry commits and the new entry loads in the same edge.
  - No bubble: sustained throughput is one write per cycle while `commit_en` is held high.
- **Illegal select**
  - An all-zero or multi-bit `wr_sel` is accepted (handshake completes) but is never loaded as pending.
  - `sel_err` ← 1.
  - If `clr_err` is asserted in the same cycle as a new error, set wins.
- **Read**
  - Reads are combinational.
  - If `pend_vld` and `pend_sel[rd_addr]` are set and `rd_addr != 0`, the read returns `pend_data` (bypass). Otherwise it returns `mem[rd_addr]`.
  - Address 0 always returns 0.
  - Both ports are independent and may hit the same word.
- **`commit_en` with no pending entry**: no effect.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n` low):
  - All `mem` words = 0.
  - `pend_vld` = 0, so `wr_ready` = 1.
  - `sel_err` = 0.
  - `rd_data_a` and `rd_data_b` = 0.
- **Reset mid-operation**: any pending write is discarded and never reaches the array.
- **Write-to-read latency**
  - Accepted at edge N: visible on the read ports (via bypass) from edge N onward.
  - Lands in `mem` at the first edge M > N with `commit_en` high.
- **Read latency**: zero cycles (combinational from the addresses and state).
- **Back-pressure**: `wr_ready` is combinational from `commit_en`. `commit_en` must not depend combinationally on `wr_ready`.
- **Handshake rule**: once `wr_valid` is asserted, the requester holds `wr_sel` and `wr_data` stable until accepted.

## Structure
- **Shared package**
  - `RF_DEPTH` = 32.
  - `RF_AWIDTH` = 5.
  - `RF_WIDTH` = 32.
  - Function `onehot_idx` (32-bit one-hot to 5-bit index, plus a valid flag). The decoder testbench reuses this function.
- **Sub-module `regfile_word`**
  - One WIDTH-bit register with asynchronous active-low reset and a load enable.
  - Instantiated 31 times (words 1..31); word 0 is a constant.
- **Top level**: handshake logic, pending stage, `sel_err`, and the two read multiplexers with bypass.

## Test plan
- **Reset**: assert `rst_n`=0 mid-write → `wr_ready`=1, `sel_err`=0, both reads of addresses 0..31 = 0, and the pending write is lost after release.
- **Basic write/commit**: `wr_sel`='b100, `wr_data`=32'hDEADBEEF, `commit_en`=0 → `rd_addr_a`=2 returns DEADBEEF via bypass and `wr_ready`=0. Pulse `commit_en` → `mem[2]`=DEADBEEF and `wr_ready`=1.
- **Back-to-back**: `commit_en` held 1, writes to words 1, 2, 3 on consecutive cycles → no stall, and reads return all three values.
- **Illegal select**: `wr_sel`=0, then `wr_sel`='b11 → no array change and `sel_err`=1. `clr_err` with no new error → `sel_err`=0. `clr_err` with a new error → `sel_err` stays 1.
- **Word 0**: `wr_sel`='b1, `wr_data`=32'hFFFFFFFF, committed → `rd_addr_a`=0 returns 0 and `sel_err`=0.
- **Dual read with bypass**: pending write to word 31 = 32'h12345678 while `mem[31]`=32'hA5A5A5A5 → both ports at address 31 return 12345678.

Source files
------------

// File: rtl/regfile_onehot_wr_pkg.sv
// Shared constants and helpers for the one-hot-write register file and its line decoder.
package regfile_onehot_wr_pkg;

    localparam int RF_DEPTH  = 32;
    localparam int RF_AWIDTH = 5;
    localparam int RF_WIDTH  = 32;

    typedef struct packed {
        logic                 valid;
        logic [RF_AWIDTH-1:0] idx;
    } onehot_idx_t;

    // valid is set only when exactly one bit is high; idx is then that bit's position.
    function automatic onehot_idx_t onehot_idx(input logic [RF_DEPTH-1:0] sel);
        onehot_idx_t r;
        int unsigned cnt;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < RF_DEPTH; i++) begin
            if (sel[i]) begin
                cnt++;
                r.idx = RF_AWIDTH'(i);
            end
        end
        r.valid = (cnt == 1);
        return r;
    endfunction

endpackage

// File: rtl/regfile_onehot_wr_word.sv
// One storage word of the register file: load-enabled register with async clear.
module regfile_word #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_onehot_wr.sv
// 32x32 register file written through a one-entry pending stage fed by a one-hot select;
// two combinational read ports see the pending entry before it commits.
module regfile_onehot_wr
    import regfile_onehot_wr_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [RF_DEPTH-1:0]  wr_sel,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 commit_en,
    input  logic [RF_AWIDTH-1:0] rd_addr_a,
    output logic [WIDTH-1:0]     rd_data_a,
    input  logic [RF_AWIDTH-1:0] rd_addr_b,
    output logic [WIDTH-1:0]     rd_data_b,
    output logic                 sel_err,
    input  logic                 clr_err
);

    if (DEPTH != RF_DEPTH) begin : g_depth_chk
        $error("regfile_onehot_wr: DEPTH must be 32 to match the line decoder");
    end

    logic                 pend_vld;
    logic [RF_DEPTH-1:0]  pend_sel;
    logic [RF_AWIDTH-1:0] pend_idx;
    logic [WIDTH-1:0]     pend_data;
    logic                 wr_acc;
    logic                 commit;
    onehot_idx_t          wr_oh;
    logic [WIDTH-1:0]     mem [RF_DEPTH];

    assign wr_oh    = onehot_idx(wr_sel);
    assign wr_ready = !pend_vld || commit_en;
    assign wr_acc   = wr_valid && wr_ready;
    assign commit   = pend_vld && commit_en;

    // Illegal selects complete the handshake but never become pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_sel  <= '0;
            pend_idx  <= '0;
            pend_data <= '0;
            sel_err   <= 1'b0;
        end else begin
            if (wr_acc) begin
                pend_vld  <= wr_oh.valid;
                pend_sel  <= wr_sel;
                pend_idx  <= wr_oh.idx;
                pend_data <= wr_data;
            end else if (commit) begin
                pend_vld <= 1'b0;
            end

            if (wr_acc && !wr_oh.valid) begin
                sel_err <= 1'b1;
            end else if (clr_err) begin
                sel_err <= 1'b0;
            end
        end
    end

    assign mem[0] = '0;

    for (genvar i = 1; i < RF_DEPTH; i++) begin : g_word
        regfile_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (commit && (pend_idx == RF_AWIDTH'(i))),
            .d     (pend_data),
            .q     (mem[i])
        );
    end

    // The pending entry shadows the array; address 0 is never bypassed.
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = (pend_vld && pend_sel[rd_addr_a]) ? pend_data : mem[rd_addr_a];
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b != '0) begin
            rd_data_b = (pend_vld && pend_sel[rd_addr_b]) ? pend_data : mem[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Bench for regfile_onehot_wr: directed vector table, random traffic against a word-level model,
// and reset corner cases.
module tb_regfile_onehot_wr;
    import regfile_onehot_wr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic        commit_en;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        sel_err;
    logic        clr_err;

    always #5 clk = ~clk;

    regfile_onehot_wr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .commit_en (commit_en),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .sel_err   (sel_err),
        .clr_err   (clr_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: array of words, one optional pending (index, data), sticky error bit.
    logic [31:0] m_mem [32];
    logic        m_pv;
    int          m_pidx;
    logic [31:0] m_pdata;
    logic        m_err;

    typedef struct {
        logic        v;
        logic [31:0] sel;
        logic [31:0] data;
        logic        ce;
        logic        clr;
        logic [4:0]  a;
        logic [4:0]  b;
        logic        rdy;
        logic        err;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (m_pv && m_pidx == a) return m_pdata;
        return m_mem[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
        m_pv    = 1'b0;
        m_pidx  = 0;
        m_pdata = 32'h0;
        m_err   = 1'b0;
    endtask

    // Advance the model by the current inputs, then clock the DUT.
    task automatic tick();
        logic rdy, acc, legal;
        int   idx;
        rdy   = !m_pv || commit_en;
        acc   = wr_valid && rdy;
        legal = ($countones(wr_sel) == 1);
        idx   = 0;
        for (int i = 0; i < 32; i++) if (wr_sel[i]) idx = i;
        if (m_pv && commit_en && m_pidx != 0) m_mem[m_pidx] = m_pdata;
        if (acc) begin
            m_pv    = legal;
            m_pidx  = idx;
            m_pdata = wr_data;
        end else if (commit_en) begin
            m_pv = 1'b0;
        end
        if (acc && !legal) m_err = 1'b1;
        else if (clr_err)  m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(!m_pv || commit_en));
        chk({tag, ".sel_err"},  32'(sel_err),  32'(m_err));
        chk({tag, ".rd_a"},     rd_data_a,     m_read(int'(rd_addr_a)));
        chk({tag, ".rd_b"},     rd_data_b,     m_read(int'(rd_addr_b)));
    endtask

    task automatic add(input logic v, input logic [31:0] sel, input logic [31:0] data,
                       input logic ce, input logic clr, input logic [4:0] a, input logic [4:0] b,
                       input logic rdy, input logic err, input logic [31:0] ea, input logic [31:0] eb);
        vec_t x;
        x.v = v; x.sel = sel; x.data = data; x.ce = ce; x.clr = clr; x.a = a; x.b = b;
        x.rdy = rdy; x.err = err; x.ea = ea; x.eb = eb;
        vt.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            chk($sformatf("%s.rd_a[%0d]", tag, i), rd_data_a, 32'h0);
            chk($sformatf("%s.rd_b[%0d]", tag, 31 - i), rd_data_b, 32'h0);
        end
    endtask

    initial begin
        // Expected values below are derived by hand from a clean reset.
        //   v  sel           data          ce clr a   b   rdy err ea            eb
        add(1, 32'h4,        32'hDEADBEEF, 0, 0, 2,  0,  1,  0,  32'h0,        32'h0);
        add(0, 32'h0,        32'h0,        0, 0, 2,  2,  0,  0,  32'hDEADBEEF, 32'hDEADBEEF);
        add(0, 32'h0,        32'h0,        1, 0, 2,  3,  1,  0,  32'hDEADBEEF, 32'h0);
        add(0, 32'h0,        32'h0,        0, 0, 2,  0,  1,  0,  32'hDEADBEEF, 32'h0);
        add(1, 32'h2,        32'h11111111, 1, 0, 1,  2,  1,  0,  32'h0,        32'hDEADBEEF);
        add(1, 32'h4,        32'h22222222, 1, 0, 1,  2,  1,  0,  32'h11111111, 32'hDEADBEEF);
        add(1, 32'h8,        32'h33333333, 1, 0, 2,  1,  1,  0,  32'h22222222, 32'h11111111);
        add(0, 32'h0,        32'h0,        0, 0, 3,  2,  0,  0,  32'h33333333, 32'h22222222);
        add(0, 32'h0,        32'h0,        1, 0, 3,  1,  1,  0,  32'h33333333, 32'h11111111);
        add(1, 32'h0,        32'hCAFE0000, 0, 0, 3,  0,  1,  0,  32'h33333333, 32'h0);
        add(1, 32'h3,        32'hCAFE0001, 0, 0, 1,  2,  1,  1,  32'h11111111, 32'h22222222);
        add(0, 32'h0,        32'h0,        0, 1, 1,  0,  1,  1,  32'h11111111, 32'h0);
        add(0, 32'h0,        32'h0,        0, 0, 0,  0,  1,  0,  32'h0,        32'h0);
        add(1, 32'h30,       32'hCAFE0002, 0, 1, 0,  0,  1,  0,  32'h0,        32'h0);
        add(0, 32'h0,        32'h0,        0, 0, 4,  5,  1,  1,  32'h0,        32'h0);
        add(1, 32'h1,        32'hFFFFFFFF, 0, 1, 0,  0,  1,  1,  32'h0,        32'h0);
        add(0, 32'h0,        32'h0,        1, 0, 0,  0,  1,  0,  32'h0,        32'h0);
        add(0, 32'h0,        32'h0,        0, 0, 0,  1,  1,  0,  32'h0,        32'h11111111);
        add(1, 32'h80000000, 32'hA5A5A5A5, 0, 0, 31, 31, 1,  0,  32'h0,        32'h0);
        add(0, 32'h0,        32'h0,        1, 0, 31, 31, 1,  0,  32'hA5A5A5A5, 32'hA5A5A5A5);
        add(1, 32'h80000000, 32'h12345678, 0, 0, 31, 30, 1,  0,  32'hA5A5A5A5, 32'h0);
        add(0, 32'h0,        32'h0,        0, 0, 31, 31, 0,  0,  32'h12345678, 32'h12345678);
        add(0, 32'h0,        32'h0,        1, 0, 31, 31, 1,  0,  32'h12345678, 32'h12345678);
        add(0, 32'h0,        32'h0,        0, 0, 31, 2,  1,  0,  32'h12345678, 32'h22222222);

        rst_n = 1'b0; wr_valid = 1'b0; wr_sel = '0; wr_data = '0;
        commit_en = 1'b0; clr_err = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        m_reset();
        #12;
        chk("reset.wr_ready", 32'(wr_ready), 32'h1);
        chk("reset.sel_err",  32'(sel_err),  32'h0);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            wr_valid = vt[i].v;  wr_sel = vt[i].sel; wr_data = vt[i].data;
            commit_en = vt[i].ce; clr_err = vt[i].clr;
            rd_addr_a = vt[i].a; rd_addr_b = vt[i].b;
            #3;
            chk($sformatf("vec%0d.wr_ready", i), 32'(wr_ready), 32'(vt[i].rdy));
            chk($sformatf("vec%0d.sel_err", i),  32'(sel_err),  32'(vt[i].err));
            chk($sformatf("vec%0d.rd_a", i),     rd_data_a,     vt[i].ea);
            chk($sformatf("vec%0d.rd_b", i),     rd_data_b,     vt[i].eb);
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            wr_valid  = ($urandom_range(3, 0) != 0);
            case ($urandom_range(7, 0))
                0:       wr_sel = 32'h0;
                1:       wr_sel = $urandom;
                default: wr_sel = 32'h1 << $urandom_range(31, 0);
            endcase
            wr_data   = $urandom;
            commit_en = 1'($urandom_range(1, 0));
            clr_err   = ($urandom_range(7, 0) == 0);
            rd_addr_a = ($urandom_range(3, 0) == 0) ? 5'(m_pidx) : 5'($urandom_range(31, 0));
            rd_addr_b = 5'($urandom_range(31, 0));
            #3;
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        // Reset while a write is pending: it must never reach the array.
        wr_valid = 1'b1; wr_sel = 32'h6; wr_data = 32'h0BAD0BAD; commit_en = 1'b1; clr_err = 1'b0;
        tick();
        wr_sel = 32'h1 << 5; wr_data = 32'h77777777; commit_en = 1'b0;
        tick();
        wr_valid = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd0;
        #1;
        chk("midrst.bypass", rd_data_a, 32'h77777777);
        chk("midrst.err_set", 32'(sel_err), 32'h1);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("midrst.wr_ready", 32'(wr_ready), 32'h1);
        chk("midrst.sel_err",  32'(sel_err),  32'h0);
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        commit_en = 1'b1;
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        tick();
        commit_en = 1'b0;
        #1;
        chk("postrst.rd_a5", rd_data_a, 32'h0);
        chk("postrst.rd_b5", rd_data_b, 32'h0);
        chk("postrst.wr_ready", 32'(wr_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
